// File: rtl/rib_stream_bridge_if.sv
// rib_stream_bridge_if
// Bundles the RIB slave bus, the TX/RX 32-bit valid/ready streams and the
// interrupt line of rib_stream_bridge.
//   slave  : view taken by the bridge (bus/stream inputs in, responses out)
//   master : view taken by whatever drives the bridge (CPU side + stream peers)
// Signals:
//   addr_i, data_i, req_i, we_i   RIB request from the interconnect
//   data_o, ack_o                 RIB response
//   tx_data_o, tx_valid_o, tx_ready_i   TX stream (bridge is the source)
//   rx_data_i, rx_valid_i, rx_ready_o   RX stream (bridge is the sink)
//   irq_o                         level interrupt
interface rib_stream_bridge_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        req_i;
  logic        we_i;
  logic        ack_o;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        irq_o;

  modport slave (
    input  addr_i, data_i, req_i, we_i, tx_ready_i, rx_data_i, rx_valid_i,
    output data_o, ack_o, tx_data_o, tx_valid_o, rx_ready_o, irq_o
  );

  modport master (
    output addr_i, data_i, req_i, we_i, tx_ready_i, rx_data_i, rx_valid_i,
    input  data_o, ack_o, tx_data_o, tx_valid_o, rx_ready_o, irq_o
  );
endinterface

// File: rtl/rib_stream_bridge.sv
// rib_stream_bridge
// RIB slave bridging bus accesses to a TX FIFO (bus writes -> stream source)
// and an RX FIFO (stream sink -> bus reads).
// Register map (addr[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   rib_stream_bridge_if.slave (RIB bus, TX/RX streams, irq_o)
// Parameter:
//   DEPTH entries per FIFO, power of two, 2..128
// Build option:
//   RIB_STREAM_IRQ_EN  when defined, CTRL[1:0] interrupt enables and the
//                      registered irq_o are built; otherwise CTRL[1:0] read 0
//                      and irq_o is tied low.
module rib_stream_bridge #(
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  rib_stream_bridge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_ovf, rx_unf;

  logic [1:0]  sel;
  logic        bus_wr, bus_rd;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, tx_ovf_set, tx_flush;
  logic        rx_push, rx_pop, rx_unf_set, rx_flush;
  logic        stat_wr, ctrl_wr;
  logic [31:0] status, ctrl_rd;

  // Only addr[3:2] decodes; upper bits alias, byte offset is irrelevant.
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:4], bus.addr_i[1:0]};

  assign sel    = bus.addr_i[3:2];
  assign bus_wr = bus.req_i & bus.we_i;
  assign bus_rd = bus.req_i & ~bus.we_i;

  // Fullness comes from the counts; pointers alone cannot tell full from empty.
  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign stat_wr = bus_wr && (sel == 2'd2);
  assign ctrl_wr = bus_wr && (sel == 2'd3);

  assign tx_push    = bus_wr && (sel == 2'd0) && !tx_full;
  assign tx_ovf_set = bus_wr && (sel == 2'd0) && tx_full;
  assign tx_pop     = bus.tx_valid_o & bus.tx_ready_i;
  assign tx_flush   = ctrl_wr & bus.data_i[2];

  // Empty-RX read does not bypass a same-cycle stream push.
  assign rx_pop     = bus_rd && (sel == 2'd1) && !rx_empty;
  assign rx_unf_set = bus_rd && (sel == 2'd1) && rx_empty;
  assign rx_push    = bus.rx_valid_i & bus.rx_ready_o;
  assign rx_flush   = ctrl_wr & bus.data_i[3];

  assign bus.ack_o      = bus.req_i;
  assign bus.tx_valid_o = ~tx_empty;
  assign bus.tx_data_o  = tx_empty ? '0 : tx_mem[tx_rp];
  assign bus.rx_ready_o = ~rst & ~rx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.data_i;
    if (rx_push && !rx_flush) rx_mem[rx_wp] <= bus.rx_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // A flush discards any word the stream offers in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Sticky error flags survive flushes; cleared only by write-1 to STATUS.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_ovf_set)                     tx_ovf <= 1'b1;
      else if (stat_wr && bus.data_i[4])  tx_ovf <= 1'b0;
      if (rx_unf_set)                     rx_unf <= 1'b1;
      else if (stat_wr && bus.data_i[5])  rx_unf <= 1'b0;
    end
  end

`ifdef RIB_STREAM_IRQ_EN
  logic rx_irq_en, tx_irq_en, irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_irq_en <= bus.data_i[0];
        tx_irq_en <= bus.data_i[1];
      end
      irq_q <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
    end
  end

  assign ctrl_rd   = {30'd0, tx_irq_en, rx_irq_en};
  assign bus.irq_o = irq_q;
`else
  assign ctrl_rd   = '0;
  assign bus.irq_o = 1'b0;
`endif

  assign status = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 2'b00, rx_unf, tx_ovf,
                   rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    bus.data_o = '0;
    if (bus_rd) begin
      case (sel)
        2'd1:    bus.data_o = rx_empty ? '0 : rx_mem[rx_rp];
        2'd2:    bus.data_o = status;
        2'd3:    bus.data_o = ctrl_rd;
        default: bus.data_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_rib_stream_bridge.sv
// tb_rib_stream_bridge
// Register-level vector table followed by directed sequences for FIFO fill,
// overflow/underflow, simultaneous events, flush, pointer wrap, interrupt lag
// and mid-run reset. Stream words are tracked in expectation queues.
module tb_rib_stream_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rib_stream_bridge_if bus ();
  rib_stream_bridge #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef RIB_STREAM_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h3;
`else
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  localparam logic [31:0] A_TX = 32'h0, A_RX = 32'h4, A_ST = 32'h8, A_CT = 32'hC;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int irq_high = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // TX stream scoreboard: every handshake must match the oldest accepted write.
  always @(negedge clk) begin
    if (!rst && bus.tx_valid_o && bus.tx_ready_i) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_stream got %h expected no word", bus.tx_data_o);
      end else begin
        check("tx_stream", bus.tx_data_o, tx_q.pop_front());
      end
    end
    if (bus.irq_o === 1'b1) irq_high++;
  end

  // All bus/stream tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.data_i = d;
    @(negedge clk);
    check("ack_wr", {31'd0, bus.ack_o}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = a;
    @(negedge clk);
    check(name, bus.data_o, exp);
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
  endtask

  task automatic rx_read();
    logic [31:0] e;
    e = (rx_q.size() == 0) ? 32'h0 : rx_q.pop_front();
    rd_check("rx_data", A_RX, e);
  endtask

  task automatic tx_write(input logic [31:0] d);
    bus_write(A_TX, d);
    tx_q.push_back(d);
  endtask

  task automatic rx_send(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.rx_valid_i = 1'b0;
    if (ok) rx_q.push_back(d);
    else check("rx_send_timeout", 32'd0, 32'd1);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    int n;
    logic [31:0] d;

    vecs[0]  = '{1'b0, A_ST,          32'h0,         32'h0000_000A};
    vecs[1]  = '{1'b0, A_TX,          32'h0,         32'h0};
    vecs[2]  = '{1'b0, A_CT,          32'h0,         32'h0};
    vecs[3]  = '{1'b1, A_CT,          32'h3,         32'h0};
    vecs[4]  = '{1'b0, A_CT,          32'h0,         CTRL_RB};
    vecs[5]  = '{1'b1, A_CT,          32'h0,         32'h0};
    vecs[6]  = '{1'b0, A_CT,          32'h0,         32'h0};
    vecs[7]  = '{1'b0, A_RX,          32'h0,         32'h0};
    vecs[8]  = '{1'b0, A_ST,          32'h0,         32'h0000_002A};
    vecs[9]  = '{1'b1, A_ST,          32'h20,        32'h0};
    vecs[10] = '{1'b0, A_ST,          32'h0,         32'h0000_000A};
    vecs[11] = '{1'b0, 32'h0FFF_FFF8, 32'h0,         32'h0000_000A};
    vecs[12] = '{1'b1, A_RX,          32'h1234,      32'h0};
    vecs[13] = '{1'b0, A_ST,          32'h0,         32'h0000_000A};
    vecs[14] = '{1'b1, A_ST,          32'hFFFF_FFCF, 32'h0};
    vecs[15] = '{1'b0, A_ST,          32'h0,         32'h0000_000A};

    bus.addr_i = '0; bus.data_i = '0; bus.req_i = 1'b0; bus.we_i = 1'b0;
    bus.tx_ready_i = 1'b0; bus.rx_data_i = '0; bus.rx_valid_i = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rx_ready_in_reset", {31'd0, bus.rx_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ack", {31'd0, bus.ack_o}, 32'd0);
    check("reset_data_o", bus.data_o, 32'd0);
    check("reset_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
    check("reset_tx_data", bus.tx_data_o, 32'd0);
    check("reset_rx_ready", {31'd0, bus.rx_ready_o}, 32'd1);
    check("reset_irq", {31'd0, bus.irq_o}, 32'd0);
    settle();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata);
      else rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // TX fill, overflow, ordered drain one word per cycle.
    for (int i = 0; i < 8; i++) tx_write(32'h11 + 32'(i));
    rd_check("tx_full_status", A_ST, 32'h0000_0809);
    bus_write(A_TX, 32'hDEAD);
    rd_check("tx_ovf_status", A_ST, 32'h0000_0819);
    bus.tx_ready_i = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.tx_valid_o) break;
      n++;
    end
    check("tx_drain_cycles", 32'(n), 32'd8);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);
    settle();
    bus.tx_ready_i = 1'b0;
    rd_check("tx_drained_status", A_ST, 32'h0000_001A);
    bus_write(A_ST, 32'h10);
    rd_check("ovf_cleared", A_ST, 32'h0000_000A);

    // RX basic, underflow, clear.
    rx_send(32'hA0);
    rx_send(32'hA1);
    rx_read();
    rx_read();
    rx_read();
    rd_check("rx_unf_status", A_ST, 32'h0000_002A);
    bus_write(A_ST, 32'h20);
    rd_check("rx_unf_cleared", A_ST, 32'h0000_000A);

    // RX full back-pressure.
    for (int i = 0; i < 8; i++) rx_send(32'hB0 + 32'(i));
    @(negedge clk);
    check("rx_ready_full", {31'd0, bus.rx_ready_o}, 32'd0);
    settle();
    rd_check("rx_full_status", A_ST, 32'h0008_0006);
    rx_read();
    @(negedge clk);
    check("rx_ready_after_pop", {31'd0, bus.rx_ready_o}, 32'd1);
    settle();
    for (int i = 0; i < 7; i++) rx_read();

    // Pointer wrap over several fill/drain rounds.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) rx_send(32'hC0 + 32'(r * 16 + i));
      for (int i = 0; i < 6; i++) rx_read();
    end
    rd_check("wrap_status", A_ST, 32'h0000_000A);

    // Empty RX read with same-cycle stream push: read 0, word kept.
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'hC5;
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = A_RX;
    @(negedge clk);
    d = bus.data_o;
    settle();
    bus.req_i = 1'b0;
    bus.rx_valid_i = 1'b0;
    check("rx_empty_pop_push", d, 32'h0);
    rx_q.push_back(32'hC5);
    rd_check("rx_pop_push_status", A_ST, 32'h0001_0022);
    rx_read();
    bus_write(A_ST, 32'h20);

    // TX full, write and stream pop together; then flush both FIFOs.
    rx_send(32'hD0);
    rx_send(32'hD1);
    for (int i = 0; i < 8; i++) tx_write(32'h21 + 32'(i));
    bus.tx_ready_i = 1'b1;
    bus_write(A_TX, 32'hBAD);
    bus.tx_ready_i = 1'b0;
    rd_check("full_push_pop_status", A_ST, 32'h0002_0710);
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 32'hEE;
    bus_write(A_CT, 32'hC);
    bus.rx_valid_i = 1'b0;
    tx_q.delete();
    rx_q.delete();
    rd_check("flush_status", A_ST, 32'h0000_001A);
    check("flush_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
    bus_write(A_ST, 32'h10);
    rx_read();
    rd_check("post_flush_status", A_ST, 32'h0000_002A);
    bus_write(A_ST, 32'h20);

`ifdef RIB_STREAM_IRQ_EN
    // RX interrupt: lags the count by one cycle on both edges.
    bus_write(A_CT, 32'h1);
    rx_send(32'h77);
    @(negedge clk);
    check("irq_rx_lag", {31'd0, bus.irq_o}, 32'd0);
    settle();
    @(negedge clk);
    check("irq_rx_set", {31'd0, bus.irq_o}, 32'd1);
    settle();
    rx_read();
    @(negedge clk);
    check("irq_rx_hold", {31'd0, bus.irq_o}, 32'd1);
    @(negedge clk);
    check("irq_rx_clear", {31'd0, bus.irq_o}, 32'd0);
    settle();
    bus_write(A_CT, 32'h2);
    settle();
    @(negedge clk);
    check("irq_tx_empty", {31'd0, bus.irq_o}, 32'd1);
    settle();
    bus_write(A_CT, 32'h0);
    settle();
    @(negedge clk);
    check("irq_disabled", {31'd0, bus.irq_o}, 32'd0);
    settle();
`else
    check("irq_never", 32'(irq_high), 32'd0);
`endif

    // Reset in the middle of traffic discards everything.
    tx_write(32'h55);
    tx_write(32'h66);
    rx_send(32'h99);
    rst = 1'b1;
    settle();
    @(negedge clk);
    check("rx_ready_rst_high", {31'd0, bus.rx_ready_o}, 32'd0);
    settle();
    rst = 1'b0;
    tx_q.delete();
    rx_q.delete();
    @(negedge clk);
    check("rst_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
    check("rst_tx_data", bus.tx_data_o, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready_o}, 32'd1);
    check("rst_irq", {31'd0, bus.irq_o}, 32'd0);
    settle();
    rd_check("rst_status", A_ST, 32'h0000_000A);
    rd_check("rst_ctrl", A_CT, 32'h0);
    rx_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
